// File: rtl/count_seq_checker.sv
// Sequence checker for a free-running counter: verifies each sample is the previous +1,
// locks after a run of good steps, flags breaks in lock and counts wraps.
module count_seq_checker #(
  parameter int CW          = 2,
  parameter int LOCK_CYCLES = 4,
  parameter int WRAP_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CW-1:0]     count_in,
  input  logic              en,
  input  logic              err_clr,
  output logic [1:0]        state_out,
  output logic              locked,
  output logic              seq_err,
  output logic              err_sticky,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int RW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [RW-1:0] RUN_LAST = RW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACQ  = 2'b01,
    LOCK = 2'b10,
    ERR  = 2'b11
  } state_t;

  state_t              state_p1, state_nx;
  logic [CW-1:0]       prev_p1;
  logic [CW-1:0]       prev_inc;
  logic [RW-1:0]       run_p1, run_nx;
  logic                step_ok;
  logic                seq_err_nx, wrap_nx, sticky_nx;
  logic [WRAP_W-1:0]   wcnt_nx;

  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  assign prev_inc = prev_p1 + 1'b1;
  assign step_ok  = (count_in == prev_inc);

  always_comb begin
    state_nx   = state_p1;
    run_nx     = run_p1;
    seq_err_nx = 1'b0;
    wrap_nx    = 1'b0;
    sticky_nx  = err_sticky;
    wcnt_nx    = wrap_cnt;
    if (en) begin
      // Clear is applied first so a same-edge error set overrides it.
      if (err_clr) sticky_nx = 1'b0;
      case (state_p1)
        IDLE: begin
          state_nx = ACQ;
          run_nx   = '0;
        end
        ACQ: begin
          if (!step_ok) begin
            run_nx = '0;
          end else if (run_p1 == RUN_LAST) begin
            state_nx = LOCK;
            run_nx   = '0;
          end else begin
            run_nx = run_p1 + 1'b1;
          end
        end
        LOCK: begin
          if (!step_ok) begin
            state_nx   = ERR;
            seq_err_nx = 1'b1;
            sticky_nx  = 1'b1;
          end else if (count_in == '0) begin
            wrap_nx = 1'b1;
            wcnt_nx = sat_inc(wrap_cnt);
          end
        end
        ERR: begin
          state_nx = ACQ;
          run_nx   = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p1: sampled state and registered flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1   <= IDLE;
      prev_p1    <= '0;
      run_p1     <= '0;
      locked     <= 1'b0;
      seq_err    <= 1'b0;
      err_sticky <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state_p1   <= state_nx;
      run_p1     <= run_nx;
      locked     <= (state_nx == LOCK);
      seq_err    <= seq_err_nx;
      err_sticky <= sticky_nx;
      wrap_pulse <= wrap_nx;
      wrap_cnt   <= wcnt_nx;
      if (en) prev_p1 <= count_in;
    end
  end

  assign state_out = state_p1;

endmodule

// File: tb/tb_count_seq_checker.sv
// Scoreboard bench for count_seq_checker: directed steps push expected outputs,
// a monitor pops and compares one entry per clock edge.
module tb_count_seq_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] count_in;
  logic       en;
  logic       err_clr;
  logic [1:0] state_out;
  logic       locked, seq_err, err_sticky, wrap_pulse;
  logic [1:0] wrap_cnt;

  int n_total = 0;
  int n_pass  = 0;
  int vec_idx = 0;

  typedef struct {
    logic [7:0] exp;
    int         idx;
  } exp_t;
  exp_t sb_q[$];

  count_seq_checker #(.CW(2), .LOCK_CYCLES(4), .WRAP_W(2)) dut (
    .clk(clk), .reset(reset), .count_in(count_in), .en(en), .err_clr(err_clr),
    .state_out(state_out), .locked(locked), .seq_err(seq_err),
    .err_sticky(err_sticky), .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {state_out, locked, seq_err, err_sticky, wrap_pulse, wrap_cnt};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got st/lk/se/sk/wp/wc=%b_%b%b%b%b_%b required %b_%b%b%b%b_%b", name,
               act[7:6], act[5], act[4], act[3], act[2], act[1:0],
               exp[7:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    else
      n_pass++;
  endtask

  // st: 0 IDLE, 1 ACQ, 2 LOCK, 3 ERR
  task automatic step(input logic e, input logic c, input logic [1:0] cin,
                      input logic [1:0] st, input logic se, input logic sk,
                      input logic wp, input logic [1:0] wc);
    exp_t x;
    @(negedge clk);
    en       = e;
    err_clr  = c;
    count_in = cin;
    vec_idx++;
    x.exp = {st, (st == 2'd2), se, sk, wp, wc};
    x.idx = vec_idx;
    sb_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        check($sformatf("vec%0d", x.idx), outs(), x.exp);
      end
    end
  end

  initial begin : driver
    reset = 1'b0; en = 1'b0; err_clr = 1'b0; count_in = 2'd0;
    #8;
    check("reset_init", outs(), 8'h00);
    #2 reset = 1'b1;

    // Acquire from IDLE, lock on 5th sample, wraps every 4th edge
    step(1,0,0, 1,0,0,0,0);
    step(1,0,1, 1,0,0,0,0);
    step(1,0,2, 1,0,0,0,0);
    step(1,0,3, 1,0,0,0,0);
    step(1,0,0, 2,0,0,0,0);
    step(1,0,1, 2,0,0,0,0);
    step(1,0,2, 2,0,0,0,0);
    step(1,0,3, 2,0,0,0,0);
    step(1,0,0, 2,0,0,1,1);
    step(1,0,1, 2,0,0,0,1);
    step(1,0,2, 2,0,0,0,1);
    step(1,0,3, 2,0,0,0,1);
    step(1,0,0, 2,0,0,1,2);
    step(1,0,1, 2,0,0,0,2);
    step(1,0,2, 2,0,0,0,2);
    step(1,0,3, 2,0,0,0,2);
    step(1,0,0, 2,0,0,1,3);
    // en=0 hold with arbitrary count_in, then resume
    step(0,0,2, 2,0,0,0,3);
    step(0,0,0, 2,0,0,0,3);
    step(0,0,3, 2,0,0,0,3);
    step(1,0,1, 2,0,0,0,3);
    // Skip a value while locked
    step(1,0,3, 3,1,1,0,3);
    step(1,0,0, 1,0,1,0,3);
    step(1,0,1, 1,0,1,0,3);
    step(1,0,2, 1,0,1,0,3);
    step(1,0,3, 1,0,1,0,3);
    step(1,0,0, 2,0,1,0,3);
    step(1,0,1, 2,0,1,0,3);
    step(1,0,2, 2,0,1,0,3);
    step(1,0,3, 2,0,1,0,3);
    step(1,0,0, 2,0,1,1,3);
    step(1,0,1, 2,0,1,0,3);
    step(1,0,2, 2,0,1,0,3);
    step(1,0,3, 2,0,1,0,3);
    step(1,0,0, 2,0,1,1,3);
    // err_clr alone, then together with a bad step, then alone again
    step(1,1,1, 2,0,0,0,3);
    step(1,1,3, 3,1,1,0,3);
    step(1,1,0, 1,0,0,0,3);
    // Bad step in ACQ restarts the run without an error pulse
    step(1,0,1, 1,0,0,0,3);
    step(1,0,3, 1,0,0,0,3);
    step(1,0,0, 1,0,0,0,3);
    step(1,0,1, 1,0,0,0,3);
    step(1,0,2, 1,0,0,0,3);
    step(1,0,3, 2,0,0,0,3);

    // Asynchronous reset between edges while locked
    @(negedge clk);
    en = 1'b0;
    #2 reset = 1'b0;
    #1 check("reset_async", outs(), 8'h00);
    @(negedge clk);
    reset = 1'b1;

    step(1,0,2, 1,0,0,0,0);
    step(1,0,3, 1,0,0,0,0);
    step(1,0,0, 1,0,0,0,0);
    step(1,0,1, 1,0,0,0,0);
    step(1,0,2, 2,0,0,0,0);
    step(1,0,3, 2,0,0,0,0);
    step(1,0,0, 2,0,0,1,1);

    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("sb_drained", {6'd0, (sb_q.size() == 0), 1'b0}, 8'h02);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
